oerv_state: RTL and testbench

Sequencing controller for the byte-serial (8 bits/cycle) OERV core. It runs the per-instruction flow: fetch, then register-file read request, then an optional init pass, then an optional data-bus access, then the execute/writeback pass. It generates the count-enable, byte counter and `cnt_done` strobes that clock the immediate decoder's shift network and the rest of the 4-cycle-per-word datapath.

---
 rtl/oerv_state.sv | 81 ++++++++
 tb/tb_oerv_state.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/oerv_state.sv
// Per-instruction sequencing controller for the byte-serial OERV core.
// Walks fetch -> register read -> optional init / data access -> execute, and paces the 4-byte datapath.
module oerv_state (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_ibus_cyc,
  input  logic       i_ibus_ack,
  input  logic       i_two_stage,
  input  logic       i_mem_op,
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_rf_rreq,
  input  logic       i_rf_ready,
  output logic       o_rf_wreq,
  output logic       o_cnt_en,
  output logic [1:0] o_cnt,
  output logic       o_cnt0,
  output logic       o_cnt_done,
  output logic       o_init,
  output logic       o_pc_en
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_RFREQ  = 3'd2,
    S_RFWAIT = 3'd3,
    S_INIT   = 3'd4,
    S_MEM    = 3'd5,
    S_RUN    = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_cnt;
  logic       w_last_byte;

  assign w_last_byte = (r_cnt == 2'd3);

  // The counter free-wraps 3->0, so INIT and RUN always start at byte 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (o_cnt_en) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (i_ibus_ack) w_next = S_RFREQ;
      S_RFREQ:  w_next = S_RFWAIT;
      S_RFWAIT: if (i_rf_ready) w_next = i_two_stage ? S_INIT : S_RUN;
      S_INIT:   if (w_last_byte) w_next = i_mem_op ? S_MEM : S_RUN;
      S_MEM:    if (i_dbus_ack) w_next = S_RUN;
      S_RUN:    if (w_last_byte) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decode only from registered state and counter.
  always_comb begin
    o_ibus_cyc = (r_state == S_FETCH);
    o_dbus_cyc = (r_state == S_MEM);
    o_rf_rreq  = (r_state == S_RFREQ);
    o_init     = (r_state == S_INIT);
    o_pc_en    = (r_state == S_RUN);
    o_cnt_en   = (r_state == S_INIT) || (r_state == S_RUN);
    o_cnt      = r_cnt;
    o_cnt0     = o_cnt_en && (r_cnt == 2'd0);
    o_cnt_done = o_cnt_en && w_last_byte;
    o_rf_wreq  = (r_state == S_RUN) && (r_cnt == 2'd0);
  end

endmodule

// File: tb/tb_oerv_state.sv
// Bench for oerv_state: expected per-cycle outputs come from an instruction-level timeline plan.
module tb_oerv_state;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_ibus_ack = 1'b0;
  logic       i_two_stage = 1'b0;
  logic       i_mem_op = 1'b0;
  logic       i_dbus_ack = 1'b0;
  logic       i_rf_ready = 1'b0;
  logic       o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_cnt_en;
  logic [1:0] o_cnt;
  logic       o_cnt0, o_cnt_done, o_init, o_pc_en;

  int errors = 0;
  int checks = 0;

  oerv_state dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_ibus_cyc(o_ibus_cyc), .i_ibus_ack(i_ibus_ack),
    .i_two_stage(i_two_stage), .i_mem_op(i_mem_op),
    .o_dbus_cyc(o_dbus_cyc), .i_dbus_ack(i_dbus_ack),
    .o_rf_rreq(o_rf_rreq), .i_rf_ready(i_rf_ready),
    .o_rf_wreq(o_rf_wreq), .o_cnt_en(o_cnt_en), .o_cnt(o_cnt),
    .o_cnt0(o_cnt0), .o_cnt_done(o_cnt_done), .o_init(o_init), .o_pc_en(o_pc_en)
  );

  always #5 i_clk = ~i_clk;

  // One planned cycle: expected outputs plus the inputs driven in that cycle.
  typedef struct packed {
    logic [10:0] exp;
    logic        ia;
    logic        da;
    logic        rr;
  } cyc_t;

  cyc_t plan[$];

  function automatic logic [10:0] obs();
    return {o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_cnt_en, o_cnt,
            o_cnt0, o_cnt_done, o_init, o_pc_en};
  endfunction

  // Expected vector; byte index k is only meaningful while counting.
  function automatic logic [10:0] mk(bit ibus, bit dbus, bit rreq, bit wreq,
                                     bit en, int k, bit init, bit pc);
    logic [1:0] c;
    c = en ? 2'(k) : 2'd0;
    return {ibus, dbus, rreq, wreq, en, c, en && (k == 0), en && (k == 3), init, pc};
  endfunction

  function automatic logic nz(bit noise);
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Timeline of one instruction: FETCH (fw waits), RFREQ, RFWAIT (rw waits),
  // optional 4 INIT, optional MEM (dw waits), 4 RUN. Noise puts acks where they must be ignored.
  task automatic build(input int fw, input int rw, input bit ts, input bit mo,
                       input int dw, input bit noise);
    cyc_t c;
    plan.delete();
    for (int i = 0; i <= fw; i++) begin
      c.exp = mk(1, 0, 0, 0, 0, 0, 0, 0);
      c.ia = (i == fw); c.da = nz(noise); c.rr = nz(noise);
      plan.push_back(c);
    end
    c.exp = mk(0, 0, 1, 0, 0, 0, 0, 0);
    c.ia = nz(noise); c.da = nz(noise); c.rr = nz(noise);
    plan.push_back(c);
    for (int i = 0; i <= rw; i++) begin
      c.exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
      c.ia = nz(noise); c.da = nz(noise); c.rr = (i == rw);
      plan.push_back(c);
    end
    if (ts) begin
      for (int k = 0; k < 4; k++) begin
        c.exp = mk(0, 0, 0, 0, 1, k, 1, 0);
        c.ia = nz(noise); c.da = nz(noise); c.rr = nz(noise);
        plan.push_back(c);
      end
      if (mo) begin
        for (int i = 0; i <= dw; i++) begin
          c.exp = mk(0, 1, 0, 0, 0, 0, 0, 0);
          c.ia = nz(noise); c.da = (i == dw); c.rr = nz(noise);
          plan.push_back(c);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      c.exp = mk(0, 0, 0, (k == 0), 1, k, 0, 1);
      c.ia = nz(noise); c.da = nz(noise); c.rr = nz(noise);
      plan.push_back(c);
    end
  endtask

  // Play one instruction; if abort_at >= 0, reset is asserted in the cycle after that index.
  task automatic run_instr(input string name, input int fw, input int rw, input bit ts,
                           input bit mo, input int dw, input bit noise, input int abort_at);
    int  n_en = 0;
    int  n_db = 0;
    bit  aborted = 0;
    build(fw, rw, ts, mo, dw, noise);
    i_two_stage = ts;
    i_mem_op    = mo;
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge i_clk); #1;
      i_ibus_ack = plan[i].ia;
      i_dbus_ack = plan[i].da;
      i_rf_ready = plan[i].rr;
      @(negedge i_clk);
      checks++;
      if (obs() !== plan[i].exp) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs got %b want %b", name, i, obs(), plan[i].exp);
      end
      n_en += int'(o_cnt_en);
      n_db += int'(o_dbus_cyc);
      if (i == abort_at) begin
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      i_ibus_ack = 1'($urandom_range(0, 1));
      i_dbus_ack = 1'($urandom_range(0, 1));
      i_rf_ready = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_ibus_ack = 1'b1;
      i_dbus_ack = 1'b1;
      i_rf_ready = 1'b1;
      @(negedge i_clk);
      checks++;
      if (obs() !== 11'd0) begin
        errors++;
        $display("FAIL %s after reset: outputs got %b want %b", name, obs(), 11'd0);
      end
    end else begin
      checks++;
      if (n_en != (ts ? 8 : 4)) begin
        errors++;
        $display("FAIL %s cnt_en count: got %0d want %0d", name, n_en, ts ? 8 : 4);
      end
      checks++;
      if (n_db != ((ts && mo) ? dw + 1 : 0)) begin
        errors++;
        $display("FAIL %s dbus_cyc count: got %0d want %0d", name, n_db,
                 (ts && mo) ? dw + 1 : 0);
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      if (c == 2) i_rst = 1'b0;
      i_ibus_ack = 1'($urandom_range(0, 1));
      i_dbus_ack = 1'($urandom_range(0, 1));
      i_rf_ready = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      checks++;
      if (obs() !== 11'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: outputs got %b want %b", c, obs(), 11'd0);
      end
    end
  endtask

  task automatic test_alu();
    run_instr("alu", 0, 0, 0, 0, 0, 0, -1);
    run_instr("alu_rfwait", 1, 3, 0, 0, 0, 0, -1);
  endtask

  task automatic test_load();
    run_instr("load", 0, 0, 1, 1, 4, 0, -1);
  endtask

  task automatic test_branch();
    run_instr("branch", 2, 0, 1, 0, 0, 0, -1);
  endtask

  task automatic test_spurious();
    run_instr("spur_alu", 1, 1, 0, 0, 0, 1, -1);
    run_instr("spur_load", 0, 2, 1, 1, 2, 1, -1);
    run_instr("spur_branch", 0, 0, 1, 0, 0, 1, -1);
  endtask

  task automatic test_mid_reset();
    // ALU plan: FETCH 0, RFREQ 1, RFWAIT 2, RUN 3..6 -> byte 2 at index 5.
    run_instr("rst_run", 0, 0, 0, 0, 0, 0, 5);
    run_instr("after_rst_run", 0, 0, 0, 0, 0, 0, -1);
    // Load plan: INIT 3..6, MEM 7..10 -> index 8 is mid-MEM.
    run_instr("rst_mem", 0, 0, 1, 1, 3, 0, 8);
    run_instr("after_rst_mem", 0, 1, 1, 1, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 25; n++) begin
      run_instr("random", $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_spurious();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
